// File: rtl/u_rr_arb.sv
// Round-robin arbiter with a thermometer priority mask, optional grant lock,
// zero-bubble back-to-back grants and a sticky mask-integrity flag.
module u_rr_arb #(
  parameter int N         = 8,
  parameter bit P_LOCK_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_ack,
  output logic [N-1:0]         o_gnt,
  output logic                 o_gnt_vld,
  output logic [$clog2(N)-1:0] o_gnt_id,
  output logic [N-1:0]         o_mask,
  output logic                 o_mask_err
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [N-1:0]   gnt_r, gnt_n;
  logic [W-1:0]   id_r, id_n;
  logic [N-1:0]   mask_r, mask_n;
  logic           err_r;

  logic           accept;
  logic [N-1:0]   mask_nxt, m_eff, masked, src, pick_oh, inv;
  logic [W-1:0]   pick_id;
  logic           thermo_ok;

  // Priority update and arbitration share one cycle so an ack can re-grant at once.
  always_comb begin
    accept = (state == GRANT) && i_ack;
    for (int k = 0; k < N; k++) mask_nxt[k] = (k > int'(id_r));
    if (int'(id_r) == N-1) mask_nxt = '1;
    m_eff   = accept ? mask_nxt : mask_r;
    masked  = i_req & m_eff;
    src     = (|masked) ? masked : i_req;
    pick_oh = '0;
    pick_id = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (src[k]) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_id    = W'(k);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_r;
    id_n    = id_r;
    mask_n  = mask_r;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_n = GRANT;
          gnt_n   = pick_oh;
          id_n    = pick_id;
        end else begin
          gnt_n = '0;
          id_n  = '0;
        end
      end
      GRANT: begin
        if (i_ack) begin
          mask_n = mask_nxt;
          if (|i_req) begin
            gnt_n = pick_oh;
            id_n  = pick_id;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            id_n    = '0;
          end
        end else if (!P_LOCK_EN && !(|(gnt_r & i_req))) begin
          state_n = IDLE;
          gnt_n   = '0;
          id_n    = '0;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        id_n    = '0;
      end
    endcase
  end

  // Legal mask: ones packed against the MSB, so its inverse is 2^k-1.
  always_comb begin
    inv       = ~mask_r;
    thermo_ok = (|mask_r) && ((inv & (inv + N'(1))) == '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      gnt_r  <= '0;
      id_r   <= '0;
      mask_r <= '1;
      err_r  <= 1'b0;
    end else begin
      state  <= state_n;
      gnt_r  <= gnt_n;
      id_r   <= id_n;
      mask_r <= mask_n;
      err_r  <= err_r | ~thermo_ok;
    end
  end

  assign o_gnt      = gnt_r;
  assign o_gnt_vld  = (state == GRANT);
  assign o_gnt_id   = id_r;
  assign o_mask     = mask_r;
  assign o_mask_err = err_r;
endmodule

// File: tb/tb_u_rr_arb.sv
// Directed bench for u_rr_arb at N=4, locked and unlocked instances side by side.
module tb_u_rr_arb;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;

  logic [3:0] gnt, mask, nl_gnt, nl_mask;
  logic [1:0] gid, nl_gid;
  logic       vld, err, nl_vld, nl_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  u_rr_arb #(.N(4), .P_LOCK_EN(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack),
    .o_gnt(gnt), .o_gnt_vld(vld), .o_gnt_id(gid), .o_mask(mask), .o_mask_err(err)
  );

  u_rr_arb #(.N(4), .P_LOCK_EN(1'b0)) dut_nl (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ack(ack),
    .o_gnt(nl_gnt), .o_gnt_vld(nl_vld), .o_gnt_id(nl_gid), .o_mask(nl_mask),
    .o_mask_err(nl_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tests++; if (vld !== 1'b0) begin fails++; $display("FAIL reset_vld got=%b exp=0", vld); end
    tests++; if (mask !== 4'b1111) begin fails++; $display("FAIL reset_mask got=%b exp=1111", mask); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (gid !== 2'd0) begin fails++; $display("FAIL reset_id got=%0d exp=0", gid); end
  endtask

  task automatic test_idle();
    req = 4'b0000; ack = 1'b1;
    tick();
    tests++; if (vld !== 1'b0 || gnt !== 4'b0000) begin fails++; $display("FAIL idle got vld=%b gnt=%b exp vld=0 gnt=0000", vld, gnt); end
    tests++; if (mask !== 4'b1111) begin fails++; $display("FAIL idle_mask got=%b exp=1111", mask); end
    ack = 1'b0;
  endtask

  task automatic test_rotation();
    logic [3:0] eg [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] em [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b1111};
    logic [1:0] ei [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111;
    tick();
    tests++; if (gnt !== 4'b0001 || vld !== 1'b1) begin fails++; $display("FAIL rot_first got gnt=%b vld=%b exp gnt=0001 vld=1", gnt, vld); end
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (gnt !== eg[i]) begin fails++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, gnt, eg[i]); end
      tests++; if (mask !== em[i]) begin fails++; $display("FAIL rot_mask[%0d] got=%b exp=%b", i, mask, em[i]); end
      tests++; if (gid !== ei[i]) begin fails++; $display("FAIL rot_id[%0d] got=%0d exp=%0d", i, gid, ei[i]); end
    end
    ack = 1'b0;
  endtask

  task automatic test_skip_wrap();
    do_reset();
    req = 4'b1001;
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL skip_first got=%b exp=0001", gnt); end
    ack = 1'b1;
    tick();
    tests++; if (gnt !== 4'b1000 || mask !== 4'b1110) begin fails++; $display("FAIL skip_hi got gnt=%b mask=%b exp gnt=1000 mask=1110", gnt, mask); end
    tick();
    tests++; if (gnt !== 4'b0001 || mask !== 4'b1111) begin fails++; $display("FAIL skip_wrap got gnt=%b mask=%b exp gnt=0001 mask=1111", gnt, mask); end
    ack = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b0011;
    tick();
    tests++; if (gnt !== 4'b0001 || nl_gnt !== 4'b0001) begin fails++; $display("FAIL lock_first got lk=%b nl=%b exp 0001", gnt, nl_gnt); end
    req = 4'b0010;
    tick();
    tests++; if (gnt !== 4'b0001 || vld !== 1'b1) begin fails++; $display("FAIL lock_hold got gnt=%b vld=%b exp gnt=0001 vld=1", gnt, vld); end
    tests++; if (nl_vld !== 1'b0 || nl_gnt !== 4'b0000) begin fails++; $display("FAIL nolock_drop got vld=%b gnt=%b exp vld=0 gnt=0000", nl_vld, nl_gnt); end
    tick();
    tests++; if (gnt !== 4'b0001) begin fails++; $display("FAIL lock_hold2 got=%b exp=0001", gnt); end
    tests++; if (nl_gnt !== 4'b0010 || nl_mask !== 4'b1111) begin fails++; $display("FAIL nolock_regrant got gnt=%b mask=%b exp gnt=0010 mask=1111", nl_gnt, nl_mask); end
    tests++; if (mask !== 4'b1111) begin fails++; $display("FAIL lock_mask got=%b exp=1111", mask); end
  endtask

  task automatic test_ack_wins();
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000; ack = 1'b1;
    tick();
    tests++; if (nl_vld !== 1'b0 || nl_mask !== 4'b1110) begin fails++; $display("FAIL ack_wins got vld=%b mask=%b exp vld=0 mask=1110", nl_vld, nl_mask); end
    ack = 1'b0;
  endtask

  task automatic test_late_req();
    do_reset();
    req = 4'b0100;
    tick();
    tests++; if (gnt !== 4'b0100 || gid !== 2'd2) begin fails++; $display("FAIL late_first got gnt=%b id=%0d exp gnt=0100 id=2", gnt, gid); end
    req = 4'b0011; ack = 1'b1;
    tick();
    tests++; if (gnt !== 4'b0001 || gid !== 2'd0 || vld !== 1'b1) begin fails++; $display("FAIL late_fallback got gnt=%b id=%0d vld=%b exp gnt=0001 id=0 vld=1", gnt, gid, vld); end
    tests++; if (mask !== 4'b1000) begin fails++; $display("FAIL late_mask got=%b exp=1000", mask); end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    tick();
    tests++; if (gnt !== 4'b0010) begin fails++; $display("FAIL rmid_first got=%b exp=0010", gnt); end
    rst = 1'b1; ack = 1'b1;
    tick();
    tests++; if (vld !== 1'b0 || mask !== 4'b1111 || gnt !== 4'b0000) begin fails++; $display("FAIL rmid got vld=%b gnt=%b mask=%b exp vld=0 gnt=0000 mask=1111", vld, gnt, mask); end
    rst = 1'b0; ack = 1'b0;
    tick();
    tests++; if (gnt !== 4'b0010 || vld !== 1'b1) begin fails++; $display("FAIL rmid_after got gnt=%b vld=%b exp gnt=0010 vld=1", gnt, vld); end
  endtask

  initial begin
    rst = 1'b1; req = '0; ack = 1'b0;
    test_reset();
    test_idle();
    test_rotation();
    test_skip_wrap();
    test_lock();
    test_ack_wins();
    test_late_req();
    test_reset_mid();
    tests++; if (err !== 1'b0 || nl_err !== 1'b0) begin fails++; $display("FAIL mask_err got lk=%b nl=%b exp 0", err, nl_err); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
